gpio_irq_ctrl: RTL

Input conditioner and interrupt controller for the 16 GPIO pins. It taps the same pad lines that the GPIO port drives and samples, and synchronises each input through two flops. Each input is then debounced, and rising and falling edges are detected per pin. Enabled edges latch into a pending register, which raises a level interrupt to the core. Registers are mapped on the shared data bus directly after the GPIO port block (0x4040–0x404C).

---
 rtl/gpio_irq_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gpio_irq_ctrl.sv
`timescale 1ns/1ps
// gpio_irq_ctrl: 16-pin GPIO input synchroniser, debouncer and edge interrupt controller on the data bus.
// Build option GPIO_DEBOUNCE_EN adds per-pin debounce counters; without it the level follows the synchroniser.
module gpio_irq_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [31:0] data_bus_data,
  input  logic [31:0] data_bus_addr,
  input  logic [1:0]  data_bus_mode,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_level,
  output logic        irq
);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_IDLE2 = 2'b11
  } bus_mode_t;

  typedef enum logic [1:0] {
    REG_RISE_EN = 2'd0,
    REG_FALL_EN = 2'd1,
    REG_PENDING = 2'd2,
    REG_LEVEL   = 2'd3
  } reg_sel_t;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
    $error("gpio_irq_ctrl: DEBOUNCE_CYCLES must be in 1..65535");
  end

  logic [15:0] sync1, sync2;
  logic [15:0] rise_en, fall_en, pending;
  logic [15:0] level_next, pend_set, w1c, rd_data;
  logic        hit, rd, wr;
  logic        unused_wdata_hi;
  reg_sel_t    sel;
  bus_mode_t   mode;

  // The register block occupies 0x4040..0x404C, word aligned.
  assign mode = bus_mode_t'(data_bus_mode);
  assign hit  = (data_bus_addr[31:4] == 28'h000_0404) && (data_bus_addr[1:0] == 2'b00);
  assign sel  = reg_sel_t'(data_bus_addr[3:2]);
  assign rd   = hit && (mode == MODE_READ);
  assign wr   = hit && (mode == MODE_WRITE);

  // Write data above bit 15 has no home in any register.
  assign unused_wdata_hi = ^data_bus_data[31:16];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_data = '0;
    unique case (sel)
      REG_RISE_EN: rd_data = rise_en;
      REG_FALL_EN: rd_data = fall_en;
      REG_PENDING: rd_data = pending;
      REG_LEVEL:   rd_data = gpio_level;
      default:     rd_data = '0;
    endcase
  end

  assign data_bus_data = rd ? {16'h0000, rd_data} : 32'hzzzz_zzzz;

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [16];

  // NOTE: the counter array is live state, so it is cleared by reset like any other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (sync2[i] == gpio_level[i] || cnt[i] == CNT_LAST) cnt[i] <= '0;
        else                                                 cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    level_next = gpio_level;
    for (int i = 0; i < 16; i++) begin
      if (sync2[i] != gpio_level[i] && cnt[i] == CNT_LAST) level_next[i] = sync2[i];
    end
  end
`else
  always_comb level_next = sync2;
`endif

  // Edges are judged on the flop that is about to flip, using the enables as they stand before any write.
  always_comb begin
    pend_set = (level_next & ~gpio_level & rise_en) | (~level_next & gpio_level & fall_en);
    w1c      = (wr && sel == REG_PENDING) ? data_bus_data[15:0] : 16'h0000;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      gpio_level <= '0;
      rise_en    <= '0;
      fall_en    <= '0;
      pending    <= '0;
    end else begin
      sync1      <= gpio_in;
      sync2      <= sync1;
      gpio_level <= level_next;
      pending    <= (pending & ~w1c) | pend_set;
      if (wr && sel == REG_RISE_EN) rise_en <= data_bus_data[15:0];
      if (wr && sel == REG_FALL_EN) fall_en <= data_bus_data[15:0];
    end
  end

  assign irq = |pending;

endmodule
